seg7_sr_driver: RTL and testbench
=================================

Name: seg7_sr_driver

Overview:
Parametrised hex 7-segment display driver behind a valid/ready input. Accepts a magnitude plus sign flag and builds one full frame: hex digits, optional leading-zero blanking and a '-' sign. Shifts the frame serially into an external shift-register chain with a divided shift clock, then pulses latch. Every transfer writes the whole chain, so stale digits are always overwritten. Sits between the calculator datapath and the board's display shift registers.

Parameters:
DATA_WIDTH, 16, width of the magnitude input.
NUM_7_SEG_DISPLAYS, 5, number of digits in the chain; frame B = 8*NUM_7_SEG_DISPLAYS bits.
CLK_DIV, 2, clk cycles per o_sr_clk half-period (>=1).
BLANK_LEADING_ZEROS, 1, 1 = blank leading zero digits.
SEG_ACTIVE_LOW, 0, 1 = invert all 8 bits of every digit before shifting.

Ports:
clk  input  1  system clock.
rst_n  input  1  reset: asynchronous, active-low.
i_data  input  DATA_WIDTH  magnitude to display (absolute value).
i_data_is_neg  input  1  value is negative.
i_valid  input  1  input valid.
o_ready  output  1  driver idle and able to accept.
o_sr_data  output  1  serial data; stable across each rising o_sr_clk edge.
o_sr_clk  output  1  shift clock; chain samples on the rising edge.
o_sr_latch  output  1  storage latch pulse, high for CLK_DIV cycles.

Behaviour:
- All outputs are registered. Reset values: o_sr_data=0, o_sr_clk=0, o_sr_latch=0, o_ready=0. Reset enters LOAD with a blank-frame request.
- Digit code bit0=a..bit6=g, bit7=dp. dp is always 0.
- Hex table 0-F: 3F,06,5B,4F,66,6D,7D,07,7F,6F,77,7C,39,5E,79,71. Minus = 40. Blank = 00.
- Digit k (k=0 is the least significant) shows nibble k of i_data, zero-extended to 4*NUM_7_SEG_DISPLAYS bits. Higher nibbles are truncated.
- sig = index of the highest nonzero nibble + 1, minimum 1. A value of 0 displays "0".
- With blanking on, digits k >= sig are blank. With blanking off, all digits are shown.
- Sign applies only when i_data_is_neg=1 and the truncated value is nonzero. There is no "-0".
- Sign position p = min(sig, N-1) with blanking on, p = N-1 with blanking off. Digit p becomes minus, overriding its nibble.
- SEG_ACTIVE_LOW inverts the whole 8-bit digit, including blank and dp.
- Shift order: digit N-1 first, down to digit 0; bit7 first, bit0 last within each digit.
- FSM:
  - IDLE: o_ready=1. On i_valid&&o_ready, capture inputs and go to LOAD.
  - LOAD, 1 cycle: register the B-bit frame from the captured inputs or the blank request; go to SHIFT_LO.
  - SHIFT_LO, CLK_DIV cycles: o_sr_clk=0, o_sr_data=current bit; go to SHIFT_HI.
  - SHIFT_HI, CLK_DIV cycles: o_sr_clk=1, data held; advance bit counter. Go to SHIFT_LO if bits remain, else LATCH.
  - LATCH, CLK_DIV cycles: o_sr_clk=0, o_sr_latch=1; go to IDLE.
- Latency: o_ready rises exactly 1 + (2B+1)*CLK_DIV cycles after the accepting edge. The default is 163 cycles.
- The first o_ready after reset release follows the same count, after an all-blank frame (00, or FF when active-low).
- o_ready=0 outside IDLE. i_valid there is ignored and is not queued. i_data/i_data_is_neg changes after capture have no effect.
- Reset mid-frame: outputs return to reset values immediately. The partial chain content is overwritten by the post-reset blank frame.
- Counters: bit counter width $clog2(B). Divider counter width $clog2(CLK_DIV+1). Neither counter wraps outside its state.

Decomposition:
- seg7_pkg holds:
  - the 8-bit segment typedef;
  - SEG_BLANK and SEG_MINUS constants;
  - the hex-to-segment function;
  - the FSM state enum.
- Sub-module seg7_frame_builder (combinational): captured data, sign, parameters -> B-bit frame, including blanking, sign placement and polarity.
- FSM, divider and shifter live in seg7_sr_driver.

Test Plan:
- Reset release, defaults -> 40 rising o_sr_clk edges with data 0, one latch pulse of 2 cycles. o_ready high 163 cycles after reset release.
- i_data=0x00A5, neg=0 -> captured frame digits 4..0 = 00,00,00,77,6D. Check serial bit order and o_ready latency of 163.
- i_data=0x1234, neg=1 -> 40,06,5B,4F,66. i_data=0x0000, neg=1 -> 00,00,00,00,3F.
- BLANK_LEADING_ZEROS=0, SEG_ACTIVE_LOW=1, i_data=0x0007, neg=1 -> inverted BF,C0,C0,C0,F8.
- NUM_7_SEG_DISPLAYS=4, i_data=0xF00D, neg=1 -> 40,C0... no: sign overrides digit 3 -> 40,3F,3F,5E.
- i_valid held high during a frame plus rst_n pulsed mid-shift -> no second accept while busy. After reset: outputs zero, blank frame resent, then exactly one accept.

Source files
------------

// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seg7_pkg
// Brief    : Shared segment type, segment constants, hex decoder, FSM states.
// Revision : 1.0
// ============================================================================
package seg7_pkg;

  // Bit 0 = segment a ... bit 6 = segment g, bit 7 = decimal point.
  typedef logic [7:0] seg_t;

  localparam seg_t SEG_BLANK = 8'h00;
  localparam seg_t SEG_MINUS = 8'h40;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_SHIFT_LO = 3'd2,
    ST_SHIFT_HI = 3'd3,
    ST_LATCH    = 3'd4
  } state_t;

  function automatic seg_t hex_to_seg(input logic [3:0] nib);
    seg_t seg;
    case (nib)
      4'h0: seg = 8'h3F;
      4'h1: seg = 8'h06;
      4'h2: seg = 8'h5B;
      4'h3: seg = 8'h4F;
      4'h4: seg = 8'h66;
      4'h5: seg = 8'h6D;
      4'h6: seg = 8'h7D;
      4'h7: seg = 8'h07;
      4'h8: seg = 8'h7F;
      4'h9: seg = 8'h6F;
      4'hA: seg = 8'h77;
      4'hB: seg = 8'h7C;
      4'hC: seg = 8'h39;
      4'hD: seg = 8'h5E;
      4'hE: seg = 8'h79;
      default: seg = 8'h71;
    endcase
    return seg;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_frame_builder.sv
`default_nettype none
// ============================================================================
// Module   : seg7_frame_builder
// Brief    : Combinational magnitude+sign to full display frame (digit N-1 on top).
// Revision : 1.0
// ============================================================================
module seg7_frame_builder
  import seg7_pkg::*;
#(
  parameter int DATA_WIDTH          = 16,
  parameter int NUM_7_SEG_DISPLAYS  = 5,
  parameter int BLANK_LEADING_ZEROS = 1,
  parameter int SEG_ACTIVE_LOW      = 0
) (
  input  logic [DATA_WIDTH-1:0]           i_data,
  input  logic                            i_data_is_neg,
  input  logic                            i_blank,
  output logic [8*NUM_7_SEG_DISPLAYS-1:0] o_frame
);

  localparam int c_NIB_W = 4 * NUM_7_SEG_DISPLAYS;

  logic [c_NIB_W-1:0] w_value;
  logic               w_show_sign;
  int                 w_sig;
  int                 w_pos;
  seg_t               w_seg;

  generate
    if (DATA_WIDTH >= c_NIB_W) begin : g_trunc
      assign w_value = i_data[c_NIB_W-1:0];
    end else begin : g_ext
      assign w_value = {{(c_NIB_W-DATA_WIDTH){1'b0}}, i_data};
    end
  endgenerate

  // Number of significant digits; a zero value still shows one "0".
  always_comb begin
    w_sig = 1;
    for (int k = 0; k < NUM_7_SEG_DISPLAYS; k++) begin
      if (w_value[4*k +: 4] != 4'h0) w_sig = k + 1;
    end
  end

  assign w_show_sign = i_data_is_neg && (w_value != '0);
  assign w_pos = (BLANK_LEADING_ZEROS != 0) ?
                 ((w_sig < NUM_7_SEG_DISPLAYS - 1) ? w_sig : NUM_7_SEG_DISPLAYS - 1) :
                 NUM_7_SEG_DISPLAYS - 1;

  always_comb begin
    o_frame = '0;
    w_seg   = SEG_BLANK;
    for (int k = 0; k < NUM_7_SEG_DISPLAYS; k++) begin
      w_seg = hex_to_seg(w_value[4*k +: 4]);
      if ((BLANK_LEADING_ZEROS != 0) && (k >= w_sig)) w_seg = SEG_BLANK;
      if (w_show_sign && (k == w_pos))                w_seg = SEG_MINUS;
      if (i_blank)                                    w_seg = SEG_BLANK;
      if (SEG_ACTIVE_LOW != 0)                        w_seg = ~w_seg;
      o_frame[8*k +: 8] = w_seg;
    end
  end

endmodule
`default_nettype wire

// File: rtl/seg7_sr_driver.sv
`default_nettype none
// ============================================================================
// Module   : seg7_sr_driver
// Brief    : Valid/ready 7-segment frame driver for an external shift-register chain.
// Revision : 1.0
// ============================================================================
module seg7_sr_driver
  import seg7_pkg::*;
#(
  parameter int DATA_WIDTH          = 16,
  parameter int NUM_7_SEG_DISPLAYS  = 5,
  parameter int CLK_DIV             = 2,
  parameter int BLANK_LEADING_ZEROS = 1,
  parameter int SEG_ACTIVE_LOW      = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_data_is_neg,
  input  logic                  i_valid,
  output logic                  o_ready,
  output logic                  o_sr_data,
  output logic                  o_sr_clk,
  output logic                  o_sr_latch
);

  localparam int c_FRAME_W = 8 * NUM_7_SEG_DISPLAYS;
  localparam int c_BIT_W   = $clog2(c_FRAME_W);
  localparam int c_DIV_W   = $clog2(CLK_DIV + 1);

  localparam logic [c_BIT_W-1:0] c_BIT_FIRST = c_BIT_W'(c_FRAME_W - 1);
  localparam logic [c_DIV_W-1:0] c_DIV_LAST  = c_DIV_W'(CLK_DIV - 1);

  state_t                 r_state;
  logic [DATA_WIDTH-1:0]  r_data;
  logic                   r_neg;
  logic                   r_blank_req;
  logic [c_FRAME_W-1:0]   r_frame;
  logic [c_BIT_W-1:0]     r_bit_cnt;
  logic [c_DIV_W-1:0]     r_div_cnt;

  logic [c_FRAME_W-1:0]   w_frame;
  logic                   w_div_done;
  logic                   w_next_bit;

  seg7_frame_builder #(
    .DATA_WIDTH          (DATA_WIDTH),
    .NUM_7_SEG_DISPLAYS  (NUM_7_SEG_DISPLAYS),
    .BLANK_LEADING_ZEROS (BLANK_LEADING_ZEROS),
    .SEG_ACTIVE_LOW      (SEG_ACTIVE_LOW)
  ) u_frame_builder (
    .i_data        (r_data),
    .i_data_is_neg (r_neg),
    .i_blank       (r_blank_req),
    .o_frame       (w_frame)
  );

  assign w_div_done = (r_div_cnt == c_DIV_LAST);
  // The bit counter runs from the frame MSB down to 0; this is the bit after the current one.
  assign w_next_bit = r_frame[r_bit_cnt - c_BIT_W'(1)];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_LOAD;
      r_data      <= '0;
      r_neg       <= 1'b0;
      r_blank_req <= 1'b1;
      r_frame     <= '0;
      r_bit_cnt   <= '0;
      r_div_cnt   <= '0;
      o_ready     <= 1'b0;
      o_sr_data   <= 1'b0;
      o_sr_clk    <= 1'b0;
      o_sr_latch  <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (i_valid && o_ready) begin
            r_data      <= i_data;
            r_neg       <= i_data_is_neg;
            r_blank_req <= 1'b0;
            o_ready     <= 1'b0;
            r_state     <= ST_LOAD;
          end
        end

        ST_LOAD: begin
          r_frame     <= w_frame;
          r_blank_req <= 1'b0;
          r_bit_cnt   <= c_BIT_FIRST;
          r_div_cnt   <= '0;
          o_sr_clk    <= 1'b0;
          o_sr_data   <= w_frame[c_FRAME_W-1];
          r_state     <= ST_SHIFT_LO;
        end

        ST_SHIFT_LO: begin
          if (w_div_done) begin
            r_div_cnt <= '0;
            o_sr_clk  <= 1'b1;
            r_state   <= ST_SHIFT_HI;
          end else begin
            r_div_cnt <= r_div_cnt + c_DIV_W'(1);
          end
        end

        ST_SHIFT_HI: begin
          if (w_div_done) begin
            r_div_cnt <= '0;
            o_sr_clk  <= 1'b0;
            if (r_bit_cnt == '0) begin
              o_sr_data  <= 1'b0;
              o_sr_latch <= 1'b1;
              r_state    <= ST_LATCH;
            end else begin
              r_bit_cnt <= r_bit_cnt - c_BIT_W'(1);
              o_sr_data <= w_next_bit;
              r_state   <= ST_SHIFT_LO;
            end
          end else begin
            r_div_cnt <= r_div_cnt + c_DIV_W'(1);
          end
        end

        ST_LATCH: begin
          if (w_div_done) begin
            r_div_cnt  <= '0;
            o_sr_latch <= 1'b0;
            o_ready    <= 1'b1;
            r_state    <= ST_IDLE;
          end else begin
            r_div_cnt <= r_div_cnt + c_DIV_W'(1);
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seg7_sr_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg7_sr_driver
// Brief    : Three driver configurations fed in parallel, frames decoded from the serial pins.
// Revision : 1.0
// ============================================================================
module tb_seg7_sr_driver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] i_data;
  logic        i_data_is_neg;
  logic        i_valid;
  logic [2:0]  rdy, sdat, sclk, slat;

  int cfg_n  [3] = '{5, 5, 4};
  int cfg_d  [3] = '{2, 1, 3};
  int cfg_bl [3] = '{1, 0, 1};
  int cfg_al [3] = '{0, 1, 0};
  int hex_tab[16] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07,
                      'h7F, 'h6F, 'h77, 'h7C, 'h39, 'h5E, 'h79, 'h71};

  always #5 clk = ~clk;

  seg7_sr_driver u_dut0 (
    .clk(clk), .rst_n(rst_n), .i_data(i_data), .i_data_is_neg(i_data_is_neg),
    .i_valid(i_valid), .o_ready(rdy[0]), .o_sr_data(sdat[0]), .o_sr_clk(sclk[0]),
    .o_sr_latch(slat[0]));

  seg7_sr_driver #(.DATA_WIDTH(16), .NUM_7_SEG_DISPLAYS(5), .CLK_DIV(1),
                   .BLANK_LEADING_ZEROS(0), .SEG_ACTIVE_LOW(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .i_data(i_data), .i_data_is_neg(i_data_is_neg),
    .i_valid(i_valid), .o_ready(rdy[1]), .o_sr_data(sdat[1]), .o_sr_clk(sclk[1]),
    .o_sr_latch(slat[1]));

  seg7_sr_driver #(.DATA_WIDTH(16), .NUM_7_SEG_DISPLAYS(4), .CLK_DIV(3),
                   .BLANK_LEADING_ZEROS(1), .SEG_ACTIVE_LOW(0)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .i_data(i_data), .i_data_is_neg(i_data_is_neg),
    .i_valid(i_valid), .o_ready(rdy[2]), .o_sr_data(sdat[2]), .o_sr_clk(sclk[2]),
    .o_sr_latch(slat[2]));

  // Chain model: what an external shift register plus storage latch would hold.
  logic [63:0] cap[3], last_frame[3];
  logic        p_clk[3], p_dat[3], p_lat[3];
  int          edges[3], lat_cyc[3], last_edges[3], last_lat[3], frames[3], stab_err[3];

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        cap[i]     <= '0;
        edges[i]   <= 0;
        lat_cyc[i] <= 0;
      end else begin
        if (sclk[i] && !p_clk[i]) begin
          cap[i]   <= {cap[i][62:0], sdat[i]};
          edges[i] <= edges[i] + 1;
          if (sdat[i] !== p_dat[i]) stab_err[i] <= stab_err[i] + 1;
        end
        if (slat[i]) lat_cyc[i] <= lat_cyc[i] + 1;
        if (!slat[i] && p_lat[i]) begin
          last_frame[i] <= cap[i];
          last_edges[i] <= edges[i];
          last_lat[i]   <= lat_cyc[i];
          frames[i]     <= frames[i] + 1;
          cap[i]        <= '0;
          edges[i]      <= 0;
          lat_cyc[i]    <= 0;
        end
      end
      p_clk[i] <= sclk[i];
      p_dat[i] <= sdat[i];
      p_lat[i] <= slat[i];
    end
  end

  int n_checks = 0;
  int n_fail   = 0;
  int lat_obs[3];
  int fr_before[3];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Display contents derived digit by digit from the value's arithmetic.
  function automatic logic [63:0] model(input logic [15:0] data, input bit neg, input int n,
                                        input bit bl, input bit al, input bit blank_req);
    longint unsigned v;
    int          sig, p;
    bit          sgn;
    logic [63:0] f;
    v = 64'(data);
    if (n < 16) v = v % (64'd1 << (4 * n));
    sig = 1;
    for (int k = 0; k < n; k++)
      if (((v / (64'd1 << (4 * k))) % 16) != 0) sig = k + 1;
    sgn = neg && (v != 0);
    p   = bl ? ((sig < n - 1) ? sig : n - 1) : n - 1;
    f   = '0;
    for (int k = n - 1; k >= 0; k--) begin
      int s;
      if (blank_req || (bl && k >= sig)) s = 0;
      else s = hex_tab[int'((v / (64'd1 << (4 * k))) % 16)];
      if (!blank_req && sgn && k == p) s = 'h40;
      if (al) s = s ^ 'hFF;
      f = (f << 8) | 64'(s);
    end
    return f;
  endfunction

  task automatic snap();
    for (int i = 0; i < 3; i++) fr_before[i] = frames[i];
  endtask

  // Count edges until every driver shows ready again; a missing ready leaves 0.
  task automatic measure();
    int done;
    for (int i = 0; i < 3; i++) lat_obs[i] = 0;
    for (int n = 1; n <= 3000; n++) begin
      @(posedge clk); #1;
      done = 1;
      for (int i = 0; i < 3; i++) begin
        if (rdy[i] && lat_obs[i] == 0) lat_obs[i] = n;
        if (lat_obs[i] == 0) done = 0;
      end
      if (done == 1) break;
    end
    @(negedge clk); #1;
  endtask

  task automatic check_frame(input logic [15:0] d, input bit ng, input bit br);
    for (int i = 0; i < 3; i++) begin
      check_val($sformatf("d%0d_latency_%h", i, d), 64'(lat_obs[i]),
                64'(1 + (16 * cfg_n[i] + 1) * cfg_d[i]));
      check_val($sformatf("d%0d_frame_%h_%0d", i, d, ng), last_frame[i],
                model(d, ng, cfg_n[i], cfg_bl[i] != 0, cfg_al[i] != 0, br));
      check_val($sformatf("d%0d_sr_edges", i), 64'(last_edges[i]), 64'(8 * cfg_n[i]));
      check_val($sformatf("d%0d_latch_len", i), 64'(last_lat[i]), 64'(cfg_d[i]));
      check_val($sformatf("d%0d_frame_count", i), 64'(frames[i]), 64'(fr_before[i] + 1));
    end
  endtask

  task automatic send(input logic [15:0] d, input bit ng);
    snap();
    @(negedge clk);
    i_data = d; i_data_is_neg = ng; i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    check_val("ready_low_after_accept", 64'(rdy), 64'h0);
    i_data = 16'($urandom); i_data_is_neg = 1'($urandom);
    measure();
    check_frame(d, ng, 1'b0);
  endtask

  task automatic hold_reset_test();
    int   busy_hi, n_acc;
    logic was_rdy;
    snap();
    @(negedge clk);
    i_data = 16'h5A5A; i_data_is_neg = 1'b1; i_valid = 1'b1;
    @(posedge clk); #1;
    busy_hi = 0;
    repeat (60) begin
      @(posedge clk); #1;
      if (rdy != 3'b000) busy_hi++;
    end
    check_val("busy_ignores_valid", 64'(busy_hi), 64'h0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_val("async_reset_outputs", 64'({rdy, sdat, sclk, slat}), 64'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    i_data = 16'h0BEE;
    n_acc = 0;
    for (int n = 1; n <= 3000; n++) begin
      was_rdy = rdy[0];
      @(posedge clk); #1;
      if (was_rdy) begin n_acc = n; break; end
      @(negedge clk);
    end
    i_valid = 1'b0;
    check_val("d0_accept_edge_after_reset", 64'(n_acc), 64'd164);
    check_val("d0_busy_after_reaccept", 64'(rdy[0]), 64'h0);
    check_val("d0_blank_frame_count", 64'(frames[0]), 64'(fr_before[0] + 1));
    check_val("d0_blank_frame", last_frame[0], 64'h0);
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk); #1;
      if (rdy[0]) break;
    end
    @(negedge clk); #1;
    check_val("d0_single_accept_count", 64'(frames[0]), 64'(fr_before[0] + 2));
    check_val("d0_frame_after_reset", last_frame[0], 64'h00_40_7C_79_79);
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk); #1;
      if (rdy == 3'b111) break;
    end
  endtask

  initial begin
    rst_n = 1'b0; i_valid = 1'b0; i_data = '0; i_data_is_neg = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check_val("reset_outputs", 64'({rdy, sdat, sclk, slat}), 64'h0);
    snap();
    @(negedge clk);
    rst_n = 1'b1;
    measure();
    check_frame(16'h0000, 1'b0, 1'b1);

    send(16'h00A5, 1'b0);
    send(16'h1234, 1'b1);
    send(16'h0000, 1'b1);
    send(16'h0007, 1'b1);
    send(16'hF00D, 1'b1);
    for (int t = 0; t < 12; t++) begin
      logic [15:0] m;
      case ($urandom_range(0, 4))
        0:       m = 16'h0000;
        1:       m = 16'h000F;
        2:       m = 16'h00FF;
        3:       m = 16'h0FFF;
        default: m = 16'hFFFF;
      endcase
      send(16'($urandom) & m, 1'($urandom));
    end

    hold_reset_test();

    for (int i = 0; i < 3; i++)
      check_val($sformatf("d%0d_data_stable_at_sr_clk", i), 64'(stab_err[i]), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
